// File: rtl/serializer_feed_fifo.sv
// rtl/serializer_feed_fifo.sv - valid/ready word buffer that paces one-cycle issue pulses into a serializer
// Optional counters under SERIALIZER_FEED_FIFO_STATS_EN: stall_cnt (saturating) and issue_cnt (wrapping).
module serializer_feed_fifo #(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       up_valid,
   input  logic [width-1:0]           up_data,
   output logic                       up_ready,
   input  logic                       busy,
   output logic                       parallel_valid,
   output logic [width-1:0]           parallel_data,
   output logic [$clog2(depth+1)-1:0] fifo_count
`ifdef SERIALIZER_FEED_FIFO_STATS_EN
   ,
   output logic [15:0]                stall_cnt,
   output logic [15:0]                issue_cnt
`endif
);

   localparam int AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int CW = $clog2(depth + 1);
   localparam logic [CW-1:0] FULL = CW'(depth);

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             issue;

   assign up_ready = (fifo_count != FULL);
   assign push     = up_valid && up_ready;
   // The serializer only raises busy an edge after seeing the pulse, so a live pulse blocks the next issue.
   assign issue    = (fifo_count != '0) && (busy == 1'b0) && !parallel_valid;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= up_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
         parallel_valid <= 1'b0;
         parallel_data  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (issue) begin
            rd_ptr         <= rd_ptr + 1'b1;
            parallel_valid <= 1'b1;
            parallel_data  <= mem[rd_ptr];
         end else begin
            parallel_valid <= 1'b0;
         end
         case ({push, issue})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

`ifdef SERIALIZER_FEED_FIFO_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         issue_cnt <= '0;
      end else begin
         if ((fifo_count != '0) && (busy == 1'b1) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (issue) begin
            issue_cnt <= issue_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_serializer_feed_fifo.sv
// tb/tb_serializer_feed_fifo.sv - directed self-checking bench for serializer_feed_fifo
module tb_serializer_feed_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up_valid = 1'b0;
   logic [7:0] up_data = 8'h00;
   logic       up_ready;
   logic       busy;
   logic       busy_man = 1'b0;
   logic       use_ser = 1'b0;
   logic       parallel_valid;
   logic [7:0] parallel_data;
   logic [2:0] fifo_count;
`ifdef SERIALIZER_FEED_FIFO_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] issue_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural serializer: loads on the pulse, busy for 8 cycles, one bit per cycle LSB first.
   logic        ser_busy;
   logic [7:0]  ser_sh;
   logic [3:0]  ser_cnt;
   logic [31:0] ser_bits;
   int          nbits;
   int          guard_viol;

   assign busy = use_ser ? ser_busy : busy_man;

   always #5 clk = ~clk;

   serializer_feed_fifo #(.width(8), .depth(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .up_valid(up_valid),
      .up_data(up_data),
      .up_ready(up_ready),
      .busy(busy),
      .parallel_valid(parallel_valid),
      .parallel_data(parallel_data),
      .fifo_count(fifo_count)
`ifdef SERIALIZER_FEED_FIFO_STATS_EN
      ,
      .stall_cnt(stall_cnt),
      .issue_cnt(issue_cnt)
`endif
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ser_busy   <= 1'b0;
         ser_sh     <= 8'h00;
         ser_cnt    <= 4'd0;
         ser_bits   <= 32'h0;
         nbits      <= 0;
         guard_viol <= 0;
      end else begin
         if (parallel_valid && ser_busy) guard_viol <= guard_viol + 1;
         if (ser_busy) begin
            if (nbits < 32) ser_bits[nbits] <= ser_sh[0];
            nbits   <= nbits + 1;
            ser_sh  <= ser_sh >> 1;
            ser_cnt <= ser_cnt - 4'd1;
            if (ser_cnt == 4'd1) ser_busy <= 1'b0;
         end else if (parallel_valid) begin
            ser_sh   <= parallel_data;
            ser_cnt  <= 4'd8;
            ser_busy <= 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      busy_man = 1'b0;
      use_ser  = 1'b0;
      up_valid = 1'b0;
      up_data  = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (parallel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pv: got %b want 0", parallel_valid); end
      n_cmp++; if (parallel_data !== 8'h00) begin n_bad++; $display("FAIL reset_pd: got %h want 00", parallel_data); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", up_ready); end
   endtask

   task automatic test_single_word();
      do_reset();
      up_valid = 1'b1;
      up_data  = 8'hA5;
      tick();
      up_valid = 1'b0;
      n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
      n_cmp++; if (parallel_valid !== 1'b0) begin n_bad++; $display("FAIL single_pv_early: got %b want 0", parallel_valid); end
      tick();
      n_cmp++; if (parallel_valid !== 1'b1) begin n_bad++; $display("FAIL single_pv: got %b want 1", parallel_valid); end
      n_cmp++; if (parallel_data !== 8'hA5) begin n_bad++; $display("FAIL single_pd: got %h want a5", parallel_data); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
      tick();
      n_cmp++; if (parallel_valid !== 1'b0) begin n_bad++; $display("FAIL single_pv_after: got %b want 0", parallel_valid); end
      n_cmp++; if (parallel_data !== 8'hA5) begin n_bad++; $display("FAIL single_pd_hold: got %h want a5", parallel_data); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      do_reset();
      busy_man = 1'b1;
      for (int i = 0; i < 3; i++) begin
         up_valid = 1'b1;
         up_data  = words[i];
         tick();
      end
      up_valid = 1'b0;
      n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", fifo_count); end
      busy_man = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (parallel_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_pv_hi%0d: got %b want 1", i, parallel_valid); end
         n_cmp++; if (parallel_data !== words[i]) begin n_bad++; $display("FAIL b2b_pd%0d: got %h want %h", i, parallel_data, words[i]); end
         tick();
         n_cmp++; if (parallel_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_pv_lo%0d: got %b want 0", i, parallel_valid); end
      end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL b2b_count_end: got %0d want 0", fifo_count); end
   endtask

   task automatic test_full_simultaneous();
      logic [7:0] exp_rest [4];
      exp_rest[0] = 8'h02; exp_rest[1] = 8'h03; exp_rest[2] = 8'h04; exp_rest[3] = 8'h05;
      do_reset();
      busy_man = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         up_valid = 1'b1;
         up_data  = 8'(i);
         tick();
      end
      n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", fifo_count); end
      n_cmp++; if (up_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", up_ready); end
      up_data = 8'h05;
      tick();
      n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_ignore: got %0d want 4", fifo_count); end
      busy_man = 1'b0;
      tick();
      busy_man = 1'b1;
      n_cmp++; if (parallel_valid !== 1'b1) begin n_bad++; $display("FAIL full_issue_pv: got %b want 1", parallel_valid); end
      n_cmp++; if (parallel_data !== 8'h01) begin n_bad++; $display("FAIL full_issue_pd: got %h want 01", parallel_data); end
      n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL full_count3: got %0d want 3", fifo_count); end
      n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_back: got %b want 1", up_ready); end
      tick();
      up_valid = 1'b0;
      n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_refill: got %0d want 4", fifo_count); end
      busy_man = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (parallel_valid !== 1'b1) begin n_bad++; $display("FAIL full_drain_pv%0d: got %b want 1", i, parallel_valid); end
         n_cmp++; if (parallel_data !== exp_rest[i]) begin n_bad++; $display("FAIL full_drain_pd%0d: got %h want %h", i, parallel_data, exp_rest[i]); end
         tick();
      end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL full_drain_end: got %0d want 0", fifo_count); end
   endtask

   task automatic test_burst_serializer();
      int budget;
      do_reset();
      use_ser = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         up_valid = 1'b1;
         up_data  = 8'(i);
         tick();
      end
      up_valid = 1'b0;
      n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL burst_count: got %0d want 3", fifo_count); end
      budget = 0;
      while (nbits < 32 && budget < 300) begin
         tick();
         budget++;
      end
      n_cmp++; if (nbits !== 32) begin n_bad++; $display("FAIL burst_nbits: got %0d want 32 (timeout)", nbits); end
      n_cmp++; if (ser_bits !== 32'h04030201) begin n_bad++; $display("FAIL burst_stream: got %h want 04030201", ser_bits); end
      n_cmp++; if (guard_viol !== 0) begin n_bad++; $display("FAIL burst_pv_while_busy: got %0d want 0", guard_viol); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL burst_count_end: got %0d want 0", fifo_count); end
      use_ser = 1'b0;
   endtask

   task automatic test_reset_mid();
      int budget;
      do_reset();
      busy_man = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up_valid = 1'b1;
         up_data  = 8'hA0 + 8'(i);
         tick();
      end
      up_valid = 1'b0;
      busy_man = 1'b0;
      tick();
      n_cmp++; if (parallel_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pv_pre: got %b want 1", parallel_valid); end
      n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL mid_count_pre: got %0d want 3", fifo_count); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (parallel_valid !== 1'b0) begin n_bad++; $display("FAIL mid_pv_rst: got %b want 0", parallel_valid); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_count_rst: got %0d want 0", fifo_count); end
      n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_rst: got %b want 1", up_ready); end
      #1;
      rst_n = 1'b1;
      tick();
      up_valid = 1'b1;
      up_data  = 8'h3C;
      tick();
      up_valid = 1'b0;
      budget = 0;
      while (parallel_valid !== 1'b1 && budget < 20) begin
         tick();
         budget++;
      end
      n_cmp++; if (parallel_valid !== 1'b1) begin n_bad++; $display("FAIL mid_reissue_pv: got %b want 1 (timeout)", parallel_valid); end
      n_cmp++; if (parallel_data !== 8'h3C) begin n_bad++; $display("FAIL mid_reissue_pd: got %h want 3c", parallel_data); end
   endtask

`ifdef SERIALIZER_FEED_FIFO_STATS_EN
   task automatic test_stats();
      do_reset();
      busy_man = 1'b1;
      up_valid = 1'b1;
      up_data  = 8'h11;
      tick();
      up_data  = 8'h22;
      tick();
      up_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL stats_stall: got %0d want 5", stall_cnt); end
      n_cmp++; if (issue_cnt !== 16'd0) begin n_bad++; $display("FAIL stats_issue0: got %0d want 0", issue_cnt); end
      busy_man = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (issue_cnt !== 16'd2) begin n_bad++; $display("FAIL stats_issue2: got %0d want 2", issue_cnt); end
      n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL stats_stall_hold: got %0d want 5", stall_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_full_simultaneous();
      test_burst_serializer();
      test_reset_mid();
`ifdef SERIALIZER_FEED_FIFO_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
